alu_md_unit: RTL and testbench
==============================

ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, >= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port alu_op  input  2  controller class: 00 LW/SW/AUIPC add, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-007 SHALL have port funct7  input  7  instruction bits 31:25.
REQ-008 SHALL have port funct3  input  3  instruction bits 14:12.
REQ-009 SHALL have ports src_a, src_b  input  WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port branch_taken  output  1  branch condition, qualified by out_valid.
REQ-013 SHALL have port illegal  output  1  undecodable request, qualified by out_valid.

Function
REQ-014 SHALL accept a request when in_valid && in_ready at a rising edge; operands and fields registered at acceptance.
REQ-015 SHALL implement states IDLE, MUL, DIV; in_ready = 1 only in IDLE and reset low.
REQ-016 Single-cycle ops SHALL assert out_valid the cycle after acceptance, staying in IDLE (throughput 1/cycle).
REQ-017 alu_op 00 SHALL give src_a+src_b; alu_op 11 SHALL give src_b.
REQ-018 alu_op 01 SHALL give result 0 and branch_taken per funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 illegal.
REQ-019 alu_op 10, funct7 0000000/0100000 SHALL decode ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND by funct3; funct7[5] selects SUB/SRA, illegal on other funct3.
REQ-020 Shift amount SHALL be src_b[$clog2(WIDTH)-1:0]; arithmetic wraps modulo 2^WIDTH.
REQ-021 alu_op 10, funct7 0000001, funct3 0-3 (MUL, MULH, MULHSU, MULHU) SHALL enter MUL, 1 bit/cycle shift-add on magnitudes with sign fix-up; low or high WIDTH bits of 2*WIDTH product.
REQ-022 funct3 4-7 (DIV, DIVU, REM, REMU) SHALL enter DIV, 1 bit/cycle restoring division on magnitudes, quotient sign = sign xor, remainder sign = dividend sign.
REQ-023 MUL and DIV SHALL take exactly WIDTH iterations; out_valid WIDTH+1 cycles after acceptance, same edge returns to IDLE; in_ready low meanwhile.
REQ-024 Divide by zero SHALL give quotient all-ones, remainder = src_a; signed overflow (min / -1) SHALL give quotient min, remainder 0; latency unchanged.
REQ-025 Any other funct7 or undecoded combination SHALL give illegal=1, result 0, branch_taken 0, latency 1.
REQ-026 result, branch_taken, illegal SHALL hold until the next out_valid; in_valid while in_ready=0 SHALL be ignored, no backpressure on output.

Reset
REQ-027 reset high at an edge SHALL force state IDLE, out_valid 0, result 0, branch_taken 0, illegal 0, iteration counter 0.
REQ-028 reset mid MUL/DIV SHALL abort; no out_valid for the aborted op; in_ready 1 the first cycle reset is low.

Configuration
REQ-029 With ALU_MD_DIV_EN defined, DIV/DIVU/REM/REMU SHALL behave per REQ-022..024.
REQ-030 Without ALU_MD_DIV_EN, divide hardware SHALL be absent and funct3 4-7 with funct7 0000001 SHALL be illegal per REQ-025; MUL unaffected.

Verification (WIDTH=32)
REQ-031 ADD: alu_op 00, a=5, b=7 -> next cycle out_valid=1, result 12; back-to-back second request accepted the following cycle.
REQ-032 MUL a=0xFFFFFFFD, b=7 -> result 0xFFFFFFEB exactly 33 cycles after acceptance, in_ready low 32 cycles; MULH same operands -> 0xFFFFFFFF.
REQ-033 DIV 100/0 -> 0xFFFFFFFF, REM -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 alu_op 01 funct3 100, a=0xFFFFFFFF, b=1 -> branch_taken 1; funct3 110 same operands -> 0.
REQ-035 reset asserted at DIV iteration 10 -> next cycle out_valid 0, result 0, in_ready 1 after reset drops; no late out_valid.
REQ-036 Without ALU_MD_DIV_EN: DIVU request -> 1 cycle later out_valid 1, illegal 1, result 0.

Source files
------------

// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - RV32-style ALU with iterative multiply and optional divide (ALU_MD_DIV_EN)
// Single-cycle ops register their result at acceptance; MUL/DIV iterate one bit per cycle.
module alu_md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           r_state, w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
    logic [1:0]       r_f3;
    logic             r_neg;
    logic             r_out_valid, r_branch, r_illegal;
    logic [WIDTH-1:0] r_result;

    logic             w_accept, w_last;
    logic             w_is_mul, w_is_div, w_illegal, w_branch;
    logic [WIDTH-1:0] w_alu_res;
    logic [CW-1:0]    w_shamt;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign in_ready     = (r_state == S_IDLE) && !reset;
    assign w_accept     = in_valid && in_ready;
    assign w_last       = (r_cnt == CW'(WIDTH - 1));
    assign w_shamt      = src_b[CW-1:0];
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign branch_taken = r_branch;
    assign illegal      = r_illegal;

    always_comb begin
        w_alu_res = '0;
        w_branch  = 1'b0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        case (alu_op)
            2'b00: w_alu_res = src_a + src_b;
            2'b11: w_alu_res = src_b;
            2'b01: begin
                case (funct3)
                    3'b000:  w_branch = (src_a == src_b);
                    3'b001:  w_branch = (src_a != src_b);
                    3'b100:  w_branch = ($signed(src_a) <  $signed(src_b));
                    3'b101:  w_branch = ($signed(src_a) >= $signed(src_b));
                    3'b110:  w_branch = (src_a <  src_b);
                    3'b111:  w_branch = (src_a >= src_b);
                    default: w_illegal = 1'b1;
                endcase
            end
            default: begin
                if (funct7 == 7'b0000001) begin
                    if (!funct3[2]) begin
                        w_is_mul = 1'b1;
                    end else begin
`ifdef ALU_MD_DIV_EN
                        w_is_div = 1'b1;
`else
                        w_illegal = 1'b1;
`endif
                    end
                end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    // funct7[5] is only meaningful for SUB and SRA
                    w_illegal = funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101);
                    case (funct3)
                        3'b000: w_alu_res = funct7[5] ? src_a - src_b : src_a + src_b;
                        3'b001: w_alu_res = src_a << w_shamt;
                        3'b010: w_alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                        3'b011: w_alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
                        3'b100: w_alu_res = src_a ^ src_b;
                        3'b101: begin
                            if (funct7[5]) w_alu_res = $signed(src_a) >>> w_shamt;
                            else           w_alu_res = src_a >> w_shamt;
                        end
                        3'b110: w_alu_res = src_a | src_b;
                        default: w_alu_res = src_a & src_b;
                    endcase
                end else begin
                    w_illegal = 1'b1;
                end
            end
        endcase
        if (w_illegal) begin
            w_alu_res = '0;
            w_branch  = 1'b0;
        end
    end

    // MUL: a signed except MULHU, b signed for MUL/MULH. DIV/REM signed on funct3[0]==0.
    assign w_a_neg = src_a[WIDTH-1] && (w_is_mul ? (funct3[1:0] != 2'b11) : !funct3[0]);
    assign w_b_neg = src_b[WIDTH-1] && (w_is_mul ? !funct3[1] : !funct3[0]);
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_hi   = w_mul_sum[WIDTH:1];
    assign w_mul_lo   = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    assign w_prod     = {w_mul_hi, w_mul_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

`ifdef ALU_MD_DIV_EN
    logic             r_neg_rem;
    logic [WIDTH:0]   w_div_shift, w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_n, w_quo_n, w_quo_fix, w_rem_fix;

    // Zero divisor naturally yields all-ones quotient and |a| remainder; r_neg is forced low then.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = !w_div_diff[WIDTH];
    assign w_rem_n     = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_n     = {r_lo[WIDTH-2:0], w_div_ge};
    assign w_quo_fix   = r_neg ? -w_quo_n : w_quo_n;
    assign w_rem_fix   = r_neg_rem ? -w_rem_n : w_rem_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)      w_next_state = S_MUL;
                else if (w_accept && w_is_div) w_next_state = S_DIV;
            end
            S_MUL, S_DIV: if (w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_f3        <= '0;
            r_neg       <= 1'b0;
`ifdef ALU_MD_DIV_EN
            r_neg_rem   <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt  <= '0;
                        r_hi   <= '0;
                        r_lo   <= w_a_mag;
                        r_opnd <= w_b_mag;
                        r_f3   <= funct3[1:0];
                        r_neg  <= (w_is_div && src_b == '0) ? 1'b0 : (w_a_neg ^ w_b_neg);
`ifdef ALU_MD_DIV_EN
                        r_neg_rem <= w_a_neg;
`endif
                        if (!w_is_mul && !w_is_div) begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_branch    <= w_branch;
                            r_illegal   <= w_illegal;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_branch    <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_result    <= (r_f3 == 2'b00) ? w_prod_fix[WIDTH-1:0]
                                                       : w_prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
`ifdef ALU_MD_DIV_EN
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_hi  <= w_rem_n;
                    r_lo  <= w_quo_n;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_branch    <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_result    <= r_f3[1] ? w_rem_fix : w_quo_fix;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// tb/tb_alu_md_unit.sv - self-checking bench for alu_md_unit (WIDTH=32), honours ALU_MD_DIV_EN
module tb_alu_md_unit;
`ifdef ALU_MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b;
    logic        out_valid;
    logic [31:0] result;
    logic        branch_taken;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_md_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .result(result),
        .branch_taken(branch_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural meaning computed with 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br, output logic ill,
                                  output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sh = int'(b[4:0]);
        r = 32'h0; br = 1'b0; ill = 1'b0; lat = 1;
        if (op == 2'b00) r = a + b;
        else if (op == 2'b11) r = b;
        else if (op == 2'b01) begin
            case (f3)
                3'd0: br = (a == b);
                3'd1: br = (a != b);
                3'd4: br = (sa < sb);
                3'd5: br = (sa >= sb);
                3'd6: br = (ua < ub);
                3'd7: br = (ua >= ub);
                default: ill = 1'b1;
            endcase
        end else if (f7 == 7'h00 || f7 == 7'h20) begin
            if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
            else begin
                case (f3)
                    3'd0: r = (f7 == 7'h00) ? a + b : a - b;
                    3'd1: r = a << sh;
                    3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                    3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: begin
                        p = sa >>> sh;
                        r = (f7 == 7'h00) ? a >> sh : p[31:0];
                    end
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
        end else if (f7 == 7'h01) begin
            if (f3 < 3'd4) begin
                lat = 33;
                case (f3)
                    3'd0: begin p = sa * sb; r = p[31:0];  end
                    3'd1: begin p = sa * sb; r = p[63:32]; end
                    3'd2: begin p = sa * ub; r = p[63:32]; end
                    default: begin p = ua * ub; r = p[63:32]; end
                endcase
            end else if (!DIV_EN) ill = 1'b1;
            else begin
                lat = 33;
                if (b == 32'h0) r = f3[1] ? a : 32'hFFFFFFFF;
                else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
                    r = f3[1] ? 32'h0 : 32'h80000000;
                else begin
                    case (f3)
                        3'd4: p = sa / sb;
                        3'd5: p = ua / ub;
                        3'd6: p = sa % sb;
                        default: p = ua % ub;
                    endcase
                    r = p[31:0];
                end
            end
        end else ill = 1'b1;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] er;
        logic eb, ei;
        int elat, lat, busy;
        model(op, f7, f3, a, b, er, eb, ei, elat);
        @(negedge clk);
        check("ready_before", {63'b0, in_ready}, 64'd1);
        alu_op = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = noise;
        if (noise) begin
            alu_op = 2'b00; src_a = $urandom; src_b = $urandom;
        end
        lat = 0; busy = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (!in_ready) busy++;
            if (lat > 40) break;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'(elat));
        check("busy_cycles", 64'(busy), 64'(elat - 1));
        check("result", {32'b0, result}, {32'b0, er});
        check("branch", {63'b0, branch_taken}, {63'b0, eb});
        check("illegal", {63'b0, illegal}, {63'b0, ei});
        @(negedge clk);
        check("pulse", {63'b0, out_valid}, 64'd0);
        check("hold", {32'b0, result}, {32'b0, er});
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [2:0]  f3_busy;
        int          late;

        reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct7 = 7'h0; funct3 = 3'h0;
        src_a = 32'h0; src_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_branch", {63'b0, branch_taken}, 64'd0);
        check("rst_illegal", {63'b0, illegal}, 64'd0);
        check("rst_ready", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {63'b0, in_ready}, 64'd1);

        // Back-to-back ADD then SUB
        @(negedge clk);
        alu_op = 2'b00; src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_op = 2'b10; funct7 = 7'h20; funct3 = 3'd0;
        @(negedge clk);
        check("b2b_valid1", {63'b0, out_valid}, 64'd1);
        check("b2b_add", {32'b0, result}, 64'd12);
        check("b2b_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid2", {63'b0, out_valid}, 64'd1);
        check("b2b_sub", {32'b0, result}, 64'hFFFFFFFE);

        run_op(2'b10, 7'h01, 3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("mul_const", {32'b0, result}, 64'hFFFFFFEB);
        run_op(2'b10, 7'h01, 3'd1, 32'hFFFFFFFD, 32'd7, 1'b1);
        check("mulh_const", {32'b0, result}, 64'hFFFFFFFF);
        run_op(2'b10, 7'h01, 3'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op(2'b10, 7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(2'b10, 7'h01, 3'd4, 32'd100, 32'd0, 1'b0);
        run_op(2'b10, 7'h01, 3'd6, 32'd100, 32'd0, 1'b0);
        run_op(2'b10, 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_op(2'b10, 7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(2'b10, 7'h01, 3'd4, 32'hFFFFFF9C, 32'd0, 1'b0);
        run_op(2'b10, 7'h01, 3'd6, 32'hFFFFFF9B, 32'd7, 1'b0);
        run_op(2'b10, 7'h01, 3'd5, 32'd100, 32'd7, 1'b0);
        run_op(2'b01, 7'h00, 3'd4, 32'hFFFFFFFF, 32'd1, 1'b0);
        check("blt_const", {63'b0, branch_taken}, 64'd1);
        run_op(2'b01, 7'h00, 3'd6, 32'hFFFFFFFF, 32'd1, 1'b0);
        check("bltu_const", {63'b0, branch_taken}, 64'd0);
        run_op(2'b01, 7'h00, 3'd2, 32'd3, 32'd3, 1'b0);
        run_op(2'b10, 7'h20, 3'd1, 32'd3, 32'd3, 1'b0);
        run_op(2'b10, 7'h11, 3'd0, 32'd3, 32'd3, 1'b0);
        run_op(2'b10, 7'h20, 3'd5, 32'h80000000, 32'd35, 1'b0);
        run_op(2'b11, 7'h00, 3'd0, 32'd9, 32'hABCD0000, 1'b0);

        // Reset during iteration 10 of a long op
        f3_busy = DIV_EN ? 3'd4 : 3'd3;
        @(negedge clk);
        alu_op = 2'b10; funct7 = 7'h01; funct3 = f3_busy;
        src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {63'b0, out_valid}, 64'd0);
        check("abort_result", {32'b0, result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {63'b0, in_ready}, 64'd1);
        late = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) late++;
        end
        check("abort_no_late", 64'(late), 64'd0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0: begin op = 2'b00; f7 = 7'($urandom); f3 = 3'($urandom); end
                1: begin op = 2'b11; f7 = 7'($urandom); f3 = 3'($urandom); end
                2, 3: begin op = 2'b01; f7 = 7'h00; f3 = 3'($urandom); end
                4, 5: begin op = 2'b10; f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; f3 = 3'($urandom); end
                6, 7, 8: begin op = 2'b10; f7 = 7'h01; f3 = 3'($urandom); end
                default: begin op = 2'b10; f7 = 7'($urandom); f3 = 3'($urandom); end
            endcase
            run_op(op, f7, f3, pick_operand(), pick_operand(), n[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
